panda_data_mem_arbiter: RTL and testbench

PANDA_DATA_MEM_ARBITER -- requirements
Module: panda_data_mem_arbiter

---
 rtl/panda_data_mem_arbiter_if.sv | 32 +++
 rtl/panda_data_mem_arbiter.sv | 97 +++++++++
 tb/tb_panda_data_mem_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/panda_data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data memory.
// The slave modport is the arbiter view; master is the surrounding system.
interface panda_data_mem_arbiter_if;
    logic [1:0]       req_i;
    logic [1:0][31:0] addr_i;
    logic [1:0][3:0]  we_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       gnt_o;
    logic [1:0]       rvalid_o;
    logic [31:0]      rdata_o;
    logic             data_req_o;
    logic [31:0]      data_addr_o;
    logic [3:0]       data_we_o;
    logic [31:0]      data_wdata_o;
    logic             data_gnt_i;
    logic             data_rvalid_i;
    logic [31:0]      data_rdata_i;

    modport slave (
        input  req_i, addr_i, we_i, wdata_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
        output data_req_o, data_addr_o, data_we_o, data_wdata_o
    );

    modport master (
        output req_i, addr_i, we_i, wdata_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
        input  data_req_o, data_addr_o, data_we_o, data_wdata_o
    );
endinterface

// File: rtl/panda_data_mem_arbiter.sv
// Round-robin arbiter sharing one data memory port between the LSU
// and a secondary master; at most one transaction outstanding.
module panda_data_mem_arbiter (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    panda_data_mem_arbiter_if.slave   bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    logic        prio;
    logic        owner;
    logic        locked;
    logic        lock_sel;
    logic [31:0] lock_addr;
    logic [3:0]  lock_we;
    logic [31:0] lock_wdata;

    logic        sel;
    logic        issue;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;

    // A stalled request keeps its requester and fields until granted.
    always_comb begin
        if (locked)
            sel = lock_sel;
        else if (bus.req_i == 2'b01)
            sel = 1'b0;
        else if (bus.req_i == 2'b10)
            sel = 1'b1;
        else
            sel = prio;
    end

    assign issue = (state == S_IDLE) && (locked || (|bus.req_i));
    assign addr  = locked ? lock_addr  : bus.addr_i[sel];
    assign we    = locked ? lock_we    : bus.we_i[sel];
    assign wdata = locked ? lock_wdata : bus.wdata_i[sel];

    assign bus.data_req_o   = issue;
    assign bus.data_addr_o  = issue ? addr  : 32'h0;
    assign bus.data_we_o    = issue ? we    : 4'h0;
    assign bus.data_wdata_o = issue ? wdata : 32'h0;
    assign bus.rdata_o      = bus.data_rdata_i;

    always_comb begin
        bus.gnt_o = 2'b00;
        if (issue && bus.data_gnt_i)
            bus.gnt_o[sel] = 1'b1;
    end

    always_comb begin
        bus.rvalid_o = 2'b00;
        if ((state == S_WAIT) && bus.data_rvalid_i)
            bus.rvalid_o[owner] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            locked     <= 1'b0;
            lock_sel   <= 1'b0;
            lock_addr  <= 32'h0;
            lock_we    <= 4'h0;
            lock_wdata <= 32'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (issue) begin
                        if (bus.data_gnt_i) begin
                            owner  <= sel;
                            locked <= 1'b0;
                            state  <= S_WAIT;
                        end else if (!locked) begin
                            locked     <= 1'b1;
                            lock_sel   <= sel;
                            lock_addr  <= addr;
                            lock_we    <= we;
                            lock_wdata <= wdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.data_rvalid_i) begin
                        prio  <= ~owner;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_panda_data_mem_arbiter.sv
// Directed bench: stimulus pushes expected grants/responses into queues,
// a negedge monitor pops and compares whenever gnt_o or rvalid_o fires.
module tb_panda_data_mem_arbiter;
    logic clk;
    logic rst_n;

    panda_data_mem_arbiter_if bus ();

    panda_data_mem_arbiter dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] rdata;
    } rv_exp_t;

    gnt_exp_t gq[$];
    rv_exp_t  rq[$];

    int total = 0;
    int bad   = 0;

    logic [31:0] a_tab  [2];
    logic [3:0]  we_tab [2];
    logic [31:0] wd_tab [2];

    // Monitor: every grant and every response must match the next queued one.
    always @(negedge clk) begin
        gnt_exp_t g;
        rv_exp_t  r;
        if (bus.gnt_o != 2'b00) begin
            total++;
            if (gq.size() == 0) begin
                bad++;
                $display("FAIL gnt_unexpected got=%b want=none", bus.gnt_o);
            end else begin
                g = gq.pop_front();
                if (bus.gnt_o !== g.gnt || bus.data_addr_o !== g.addr ||
                    bus.data_we_o !== g.we || bus.data_wdata_o !== g.wdata) begin
                    bad++;
                    $display("FAIL gnt got=%b/%h/%b/%h want=%b/%h/%b/%h",
                             bus.gnt_o, bus.data_addr_o, bus.data_we_o,
                             bus.data_wdata_o, g.gnt, g.addr, g.we, g.wdata);
                end
            end
        end
        if (bus.rvalid_o != 2'b00) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL rvalid_unexpected got=%b want=none", bus.rvalid_o);
            end else begin
                r = rq.pop_front();
                if (bus.rvalid_o !== r.rv || bus.rdata_o !== r.rdata) begin
                    bad++;
                    $display("FAIL rvalid got=%b/%h want=%b/%h",
                             bus.rvalid_o, bus.rdata_o, r.rv, r.rdata);
                end
            end
        end
    end

    // One cycle: drive, queue expected events, check the memory-side bus.
    task automatic step(input logic [1:0] req, input logic g,
                        input logic rv, input logic [31:0] rd,
                        input logic er, input logic esel,
                        input logic [1:0] egnt, input logic [1:0] erv);
        logic [31:0] ea;
        logic [3:0]  ewe;
        logic [31:0] ewd;
        gnt_exp_t    ge;
        rv_exp_t     re;
        ea  = er ? a_tab[esel]  : 32'h0;
        ewe = er ? we_tab[esel] : 4'h0;
        ewd = er ? wd_tab[esel] : 32'h0;
        bus.req_i         = req;
        bus.data_gnt_i    = g;
        bus.data_rvalid_i = rv;
        bus.data_rdata_i  = rd;
        if (egnt != 2'b00) begin
            ge.gnt = egnt; ge.addr = ea; ge.we = ewe; ge.wdata = ewd;
            gq.push_back(ge);
        end
        if (erv != 2'b00) begin
            re.rv = erv; re.rdata = rd;
            rq.push_back(re);
        end
        @(negedge clk);
        total++;
        if (bus.data_req_o !== er || bus.data_addr_o !== ea ||
            bus.data_we_o !== ewe || bus.data_wdata_o !== ewd ||
            bus.rdata_o !== rd) begin
            bad++;
            $display("FAIL membus req=%b got=%b/%h/%b/%h/%h want=%b/%h/%b/%h/%h",
                     req, bus.data_req_o, bus.data_addr_o, bus.data_we_o,
                     bus.data_wdata_o, bus.rdata_o, er, ea, ewe, ewd, rd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_tab[0]  = 32'h0000_0100; a_tab[1]  = 32'h0000_0200;
        we_tab[0] = 4'b0000;       we_tab[1] = 4'b1100;
        wd_tab[0] = 32'h1111_2222; wd_tab[1] = 32'hABCD_ABCD;
        bus.addr_i[0]  = a_tab[0];  bus.addr_i[1]  = a_tab[1];
        bus.we_i[0]    = we_tab[0]; bus.we_i[1]    = we_tab[1];
        bus.wdata_i[0] = wd_tab[0]; bus.wdata_i[1] = wd_tab[1];
        bus.req_i = 2'b00;
        bus.data_gnt_i = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i = 32'h0;
        rst_n = 1'b0;

        // Reset: all outputs idle
        step(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        step(2'b00, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        rst_n = 1'b1;

        // Single load by requester 0
        step(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 2'b00);
        step(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        step(2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 2'b01);

        // Store by requester 1; we/wdata only while requesting
        step(2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 2'b00);
        step(2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        step(2'b00, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 2'b00, 2'b10);

        // Tie held: prio now 0, so grants go 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            logic       s;
            logic [1:0] oh;
            s  = i[0];
            oh = s ? 2'b10 : 2'b01;
            step(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, s, oh, 2'b00);
            step(2'b11, 1'b0, 1'b1, 32'h1000 + i, 1'b0, 1'b0, 2'b00, oh);
        end

        // Requester 0 transaction so that prio points at 1
        step(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 2'b00);
        step(2'b00, 1'b0, 1'b1, 32'h2222, 1'b0, 1'b0, 2'b00, 2'b01);

        // Stall lock on requester 0 despite prio=1 and req_i[1] rising
        step(2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 2'b00);
        step(2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 2'b00);
        step(2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 2'b00);
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 2'b00);
        step(2'b11, 1'b1, 1'b1, 32'h3333, 1'b0, 1'b0, 2'b00, 2'b01);
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 2'b00);
        step(2'b00, 1'b0, 1'b1, 32'h4444, 1'b0, 1'b0, 2'b00, 2'b10);

        // Spurious rvalid and grant in IDLE are ignored
        step(2'b00, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 2'b00, 2'b00);

        // Requester 0 granted, then reset abandons it in WAIT
        step(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 2'b00);
        step(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);
        rst_n = 1'b0;
        step(2'b00, 1'b0, 1'b1, 32'h6666, 1'b0, 1'b0, 2'b00, 2'b00);
        rst_n = 1'b1;
        step(2'b00, 1'b0, 1'b1, 32'h7777, 1'b0, 1'b0, 2'b00, 2'b00);

        // First tie after reset goes to requester 0
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 2'b00);
        step(2'b00, 1'b0, 1'b1, 32'h8888, 1'b0, 1'b0, 2'b00, 2'b01);
        step(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00);

        total++;
        if (gq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d/%0d want=0/0", gq.size(), rq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
